ps2_event_queue_ctrl: RTL and testbench
=======================================

Name: ps2_event_queue_ctrl

Overview:
Sits between the PS/2 keyboard decoder and the CPU MMIO bus. It captures each 16-bit key event ({break flag, ascii}) into a FIFO and pulses the decoder's read-enable to clear its holding register. It exposes DATA/STATUS/CTRL registers to software. It schedules a level interrupt using a count threshold plus an age timeout, so keystrokes are never lost between CPU polls.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
AW, 4, log2(DEPTH)
TIMEOUT, 50000, clk cycles a non-empty queue may wait before the interrupt fires regardless of threshold

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ev_valid  in  1  single-cycle pulse from decoder: new make/break event
ev_data  in  16  event word, bit8 = break, [7:0] = ascii
ev_ren  out  1  single-cycle pulse to decoder acknowledging capture
mmio_addr  in  2  0=DATA, 1=STATUS, 2=CTRL, 3=reserved (reads 0, writes ignored)
mmio_ren  in  1  read strobe
mmio_wen  in  1  write strobe
mmio_wdata  in  16  write data
mmio_rdata  out  16  read data, registered
irq  out  1  interrupt request, level, registered

Behaviour:
- Reset: FIFO empty; count=0; overflow=0; irq_en=0; threshold=1; age=0. Outputs ev_ren=0, irq=0, mmio_rdata=0.
- Push: on ev_valid, if not full (or if a pop happens in the same cycle), write ev_data at wr_ptr and increment wr_ptr mod DEPTH. ev_ren=1 on the next cycle.
- Full drop: on ev_valid while full with no coincident pop, the event is dropped, overflow is set (sticky) and ev_ren still pulses.
- DATA read: mmio_rdata = head entry one cycle after mmio_ren. Pop (rd_ptr++) occurs in the strobe cycle. Reading while empty returns 0x0000 and does not pop; there is no bypass of a same-cycle push.
- STATUS read: {overflow[15], full[14], empty[13], 4'b0, count[8:0]}; count is DEPTH when full. No side effects.
- STATUS write: bit15=1 clears overflow; other bits are ignored.
- CTRL read/write: {flush[15] (write-only, reads 0), irq_en[8], threshold[7:0]}.
- Threshold: a write of 0 stores 1; values above DEPTH are stored as written and never met.
- Flush: a CTRL write with bit15 set empties the FIFO (ptrs=0, count=0), clears overflow and age, and drops any coincident ev_valid (ev_ren still pulses). irq_en and threshold update from the same write.
- Simultaneous push+pop: count is unchanged, both pointers advance, data ordering is preserved.
- mmio_ren and mmio_wen both asserted: the write takes effect and mmio_rdata returns the pre-write value. A DATA pop still occurs.
- Age counter: clears when empty or on any pop; otherwise increments, saturating at TIMEOUT.
- IRQ state machine (registered, states IDLE/PENDING/FIRE):
  - IDLE -> PENDING when non-empty.
  - PENDING -> FIRE when count>=threshold, or age==TIMEOUT, or overflow.
  - FIRE -> IDLE when empty and overflow==0.
  - Any state -> IDLE on flush.
  - irq = irq_en && state==FIRE, registered, one cycle after entry.
  - Clearing irq_en masks irq but does not change state.
- Reset mid-operation: all contents are discarded; any decoder event in the reset cycle is lost and no ev_ren is issued.

Decomposition:
- Shared package: register address constants (DATA/STATUS/CTRL), STATUS/CTRL bit positions, irq state enum.
- One sub-module, ps2_event_fifo: synchronous circular buffer with push/pop/flush, full/empty/count.
- The controller keeps the register decode, age counter and irq FSM.

Test Plan:
- Push 0x0041, 0x0142; read DATA twice -> rdata 0x0041 then 0x0142 one cycle after each strobe; STATUS count 2→0, empty=1.
- irq_en=1, threshold=3; push 2 events, wait TIMEOUT-1 cycles -> irq=0. At TIMEOUT the FSM enters FIRE and irq=1 one cycle later; pop both -> irq=0.
- Push 17 events with DEPTH=16 -> STATUS 0xC010 (overflow, full, count 16); 17th event dropped, ev_ren still pulsed; write STATUS 0x8000 -> 0x4010.
- Full queue, ev_valid and DATA read in the same cycle -> count stays 16, no overflow, the new event is read last.
- Three queued events, CTRL write 0x8103 with coincident ev_valid -> empty, overflow=0, irq_en=1, threshold=3, irq=0, coincident event absent.
- Read DATA while empty -> 0x0000, count stays 0; assert rst with 5 queued -> next STATUS read 0x2000, irq=0.

Source files
------------

// File: rtl/ps2_event_queue_ctrl_pkg.sv
// Shared definitions for the PS/2 event queue controller: MMIO register
// addresses, register bit positions and the interrupt scheduler states.
package ps2_event_queue_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int STATUS_OVF_BIT   = 15;
    localparam int STATUS_FULL_BIT  = 14;
    localparam int STATUS_EMPTY_BIT = 13;

    localparam int CTRL_FLUSH_BIT  = 15;
    localparam int CTRL_IRQ_EN_BIT = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_FIRE    = 2'd2
    } irq_state_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous circular buffer of 16-bit key events with push, pop and flush.
// A push into a full buffer is accepted only when a pop frees a slot in the
// same cycle; flush wins over everything else.
module ps2_event_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointer/count values; pointers wrap naturally since DEPTH is 2**AW.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Event storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale words are unreachable because count/pointers are.
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_event_queue_ctrl.sv
// PS/2 event queue controller: captures decoder events into a FIFO, exposes
// DATA/STATUS/CTRL registers over MMIO, and raises a level interrupt once the
// queue reaches a count threshold or its oldest-pending age times out.
module ps2_event_queue_ctrl #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ev_valid,
    input  logic [15:0] ev_data,
    output logic        ev_ren,
    input  logic [1:0]  mmio_addr,
    input  logic        mmio_ren,
    input  logic        mmio_wen,
    input  logic [15:0] mmio_wdata,
    output logic [15:0] mmio_rdata,
    output logic        irq
);

    import ps2_event_queue_ctrl_pkg::*;

    localparam int AGE_W = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

    logic             ev_ren_q;
    logic [15:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;
    logic [7:0]       thr_q, thr_d;
    logic [AGE_W-1:0] age_q, age_d;
    irq_state_e       state_q, state_d;

    logic [15:0] fifo_head;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;
    logic [8:0]  count9;
    logic        data_rd, ctrl_wr, status_wr, flush, push, pop_taken, drop, thr_met;
    logic [15:0] status_word, ctrl_word;

    assign data_rd   = mmio_ren && (mmio_addr == ADDR_DATA);
    assign ctrl_wr   = mmio_wen && (mmio_addr == ADDR_CTRL);
    assign status_wr = mmio_wen && (mmio_addr == ADDR_STATUS);
    assign flush     = ctrl_wr && mmio_wdata[CTRL_FLUSH_BIT];
    assign push      = ev_valid && !flush;
    assign pop_taken = data_rd && !fifo_empty;
    assign drop      = push && fifo_full && !pop_taken;

    assign count9      = 9'(fifo_count);
    assign thr_met     = (count9 >= {1'b0, thr_q});
    assign status_word = {ovf_q, fifo_full, fifo_empty, 4'b0000, count9};
    assign ctrl_word   = {7'b0, irq_en_q, thr_q};

    ps2_event_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (data_rd),
        .flush_i (flush),
        .wdata_i (ev_data),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register file, read-data capture and age counter next-state.
    always_comb begin
        rdata_d  = rdata_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        thr_d    = thr_q;
        if (mmio_ren) begin
            case (mmio_addr)
                ADDR_DATA:   rdata_d = fifo_empty ? 16'h0000 : fifo_head;
                ADDR_STATUS: rdata_d = status_word;
                ADDR_CTRL:   rdata_d = ctrl_word;
                default:     rdata_d = 16'h0000;
            endcase
        end
        if (status_wr && mmio_wdata[STATUS_OVF_BIT]) ovf_d = 1'b0;
        if (drop) ovf_d = 1'b1;
        if (ctrl_wr) begin
            irq_en_d = mmio_wdata[CTRL_IRQ_EN_BIT];
            thr_d    = (mmio_wdata[7:0] == 8'd0) ? 8'd1 : mmio_wdata[7:0];
        end
        if (flush) ovf_d = 1'b0;
        if (flush || fifo_empty || pop_taken) begin
            age_d = '0;
        end else if (age_q == AGE_MAX) begin
            age_d = age_q;
        end else begin
            age_d = age_q + AGE_W'(1);
        end
    end

    // Interrupt scheduler next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (!fifo_empty) state_d = IRQ_PENDING;
            IRQ_PENDING: if (thr_met || (age_q == AGE_MAX) || ovf_q) state_d = IRQ_FIRE;
            IRQ_FIRE:    if (fifo_empty && !ovf_q) state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
        if (flush) state_d = IRQ_IDLE;
    end

    // Interrupt scheduler output, masked by irq_en.
    always_comb begin
        irq_d = irq_en_q && (state_q == IRQ_FIRE);
    end

    // Interrupt scheduler state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IRQ_IDLE;
        else     state_q <= state_d;
    end

    // Control/status registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_ren_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= 8'd1;
            age_q    <= '0;
        end else begin
            ev_ren_q <= ev_valid;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            age_q    <= age_d;
        end
    end

    assign ev_ren     = ev_ren_q;
    assign mmio_rdata = rdata_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_ps2_event_queue_ctrl.sv
// Self-checking bench for ps2_event_queue_ctrl: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ps2_event_queue_ctrl;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic [15:0] ev_data;
    logic        ev_ren;
    logic [1:0]  mmio_addr;
    logic        mmio_ren;
    logic        mmio_wen;
    logic [15:0] mmio_wdata;
    logic [15:0] mmio_rdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_event_queue_ctrl #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .ev_ren     (ev_ren),
        .mmio_addr  (mmio_addr),
        .mmio_ren   (mmio_ren),
        .mmio_wen   (mmio_wen),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .irq        (irq)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is a plain SV queue, registers are ints.
    int m_q[$];
    bit m_ovf, m_irq_en, m_ren, m_irq, m_live = 1'b0;
    int m_thr, m_age, m_st, m_rdata;

    always @(posedge clk) begin : model
        int sz, nxt_st, nxt_age;
        bit is_flush, is_pop;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_irq_en = 0; m_thr = 1; m_age = 0; m_st = 0;
            m_ren = 0; m_irq = 0; m_rdata = 0; m_live = 1;
        end else begin
            sz       = m_q.size();
            is_flush = mmio_wen && mmio_addr == 2'd2 && mmio_wdata[15];
            is_pop   = mmio_ren && mmio_addr == 2'd0 && sz > 0;
            if (mmio_ren) begin
                case (mmio_addr)
                    2'd0:    m_rdata = (sz > 0) ? m_q[0] : 0;
                    2'd1:    m_rdata = {m_ovf, (sz == DEPTH), (sz == 0), 4'b0000, 9'(sz)};
                    2'd2:    m_rdata = {m_irq_en, 8'(m_thr)};
                    default: m_rdata = 0;
                endcase
            end
            m_irq  = m_irq_en && (m_st == 2);
            nxt_st = m_st;
            if (m_st == 0 && sz > 0) nxt_st = 1;
            if (m_st == 1 && (sz >= m_thr || m_age == TIMEOUT || m_ovf)) nxt_st = 2;
            if (m_st == 2 && sz == 0 && !m_ovf) nxt_st = 0;
            if (is_flush) nxt_st = 0;
            nxt_age = (is_flush || sz == 0 || is_pop) ? 0
                    : ((m_age + 1 > TIMEOUT) ? TIMEOUT : m_age + 1);
            if (is_flush) begin
                m_q.delete();
                m_ovf = 0;
            end else begin
                if (mmio_wen && mmio_addr == 2'd1 && mmio_wdata[15]) m_ovf = 0;
                if (is_pop) void'(m_q.pop_front());
                if (ev_valid) begin
                    if (m_q.size() < DEPTH) m_q.push_back(int'(ev_data));
                    else m_ovf = 1;
                end
            end
            if (mmio_wen && mmio_addr == 2'd2) begin
                m_irq_en = mmio_wdata[8];
                m_thr    = (mmio_wdata[7:0] == 8'd0) ? 1 : int'(mmio_wdata[7:0]);
            end
            m_st  = nxt_st;
            m_age = nxt_age;
            m_ren = ev_valid;
        end
    end

    // Compare DUT outputs against the model on the falling edge of every cycle.
    always @(negedge clk) begin
        if (m_live) begin
            check("cyc_ev_ren", 16'(ev_ren), 16'(m_ren));
            check("cyc_irq", 16'(irq), 16'(m_irq));
            check("cyc_rdata", mmio_rdata, 16'(m_rdata));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        ev_valid = 1'b1; ev_data = d;
        step();
        ev_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
        mmio_addr = a; mmio_ren = 1'b1;
        step();
        mmio_ren = 1'b0;
        check(name, mmio_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        mmio_addr = a; mmio_wen = 1'b1; mmio_wdata = d;
        step();
        mmio_wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ev_valid = 1'b0; ev_data = '0; mmio_addr = '0;
        mmio_ren = 1'b0; mmio_wen = 1'b0; mmio_wdata = '0;
        step();
        rst = 1'b0;
        check("reset_rdata", mmio_rdata, 16'h0000);
        check("reset_irq", 16'(irq), 16'h0000);
        rd(2'd2, 16'h0001, "reset_ctrl");

        // Basic push then ordered reads.
        push(16'h0041);
        push(16'h0142);
        rd(2'd1, 16'h0002, "status_two");
        rd(2'd0, 16'h0041, "data_first");
        rd(2'd0, 16'h0142, "data_second");
        rd(2'd1, 16'h2000, "status_drained");
        repeat (3) step();

        // Age timeout fires the interrupt below the threshold.
        wr(2'd2, 16'h0103);
        push(16'h0033);
        push(16'h0034);
        repeat (TIMEOUT) step();
        check("irq_before_timeout", 16'(irq), 16'h0000);
        step();
        check("irq_after_timeout", 16'(irq), 16'h0001);
        rd(2'd0, 16'h0033, "timeout_pop1");
        rd(2'd0, 16'h0034, "timeout_pop2");
        repeat (3) step();
        check("irq_after_drain", 16'(irq), 16'h0000);

        // Overflow on the 17th event.
        wr(2'd2, 16'h8000);
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        check("ev_ren_on_drop", 16'(ev_ren), 16'h0001);
        rd(2'd1, 16'hC010, "status_overflow");
        wr(2'd1, 16'h8000);
        rd(2'd1, 16'h4010, "status_ovf_cleared");

        // Push and pop together on a full queue.
        ev_valid = 1'b1; ev_data = 16'h00AA; mmio_addr = 2'd0; mmio_ren = 1'b1;
        step();
        ev_valid = 1'b0; mmio_ren = 1'b0;
        check("full_pushpop_head", mmio_rdata, 16'h0100);
        rd(2'd1, 16'h4010, "full_pushpop_status");
        for (int i = 1; i < 16; i++) rd(2'd0, 16'h0100 + 16'(i), "drain_order");
        rd(2'd0, 16'h00AA, "drain_last_new");
        rd(2'd1, 16'h2000, "drain_status");

        // Flush with a coincident event.
        push(16'h0021); push(16'h0022); push(16'h0023);
        ev_valid = 1'b1; ev_data = 16'h00EE;
        wr(2'd2, 16'h8103);
        ev_valid = 1'b0;
        check("flush_ev_ren", 16'(ev_ren), 16'h0001);
        rd(2'd1, 16'h2000, "flush_status");
        rd(2'd2, 16'h0103, "flush_ctrl");
        check("flush_irq", 16'(irq), 16'h0000);

        // Simultaneous read and write returns the pre-write value.
        mmio_addr = 2'd2; mmio_ren = 1'b1; mmio_wen = 1'b1; mmio_wdata = 16'h0005;
        step();
        mmio_ren = 1'b0; mmio_wen = 1'b0;
        check("rw_prewrite", mmio_rdata, 16'h0103);
        rd(2'd2, 16'h0005, "rw_postwrite");
        wr(2'd2, 16'h0000);
        rd(2'd2, 16'h0001, "thr_zero_is_one");
        wr(2'd2, 16'h00FF);
        rd(2'd2, 16'h00FF, "thr_above_depth");

        // Empty read, reserved address, then reset mid-operation.
        rd(2'd0, 16'h0000, "empty_data");
        rd(2'd1, 16'h2000, "empty_status");
        rd(2'd3, 16'h0000, "reserved_read");
        for (int i = 0; i < 5; i++) push(16'h0050 + 16'(i));
        rst = 1'b1; ev_valid = 1'b1; ev_data = 16'h0099;
        step();
        rst = 1'b0; ev_valid = 1'b0;
        check("rst_ev_ren", 16'(ev_ren), 16'h0000);
        check("rst_rdata", mmio_rdata, 16'h0000);
        rd(2'd1, 16'h2000, "rst_status");
        check("rst_irq", 16'(irq), 16'h0000);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
